// File: rtl/char_fetch.sv
// char_fetch: text-mode fetch sequencer (VRAM word -> font ROM address -> pixel generator load).
// Optional macro CURSOR_BLINK_EN gates the cursor with a phase toggling every BLINK_FRAMES/2 frames.
module char_fetch #(
  parameter int COLS         = 80,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic [4:0]  char_row,
  input  logic [3:0]  scanline,
  input  logic [11:0] start_addr,
  input  logic        cursor_en,
  input  logic [11:0] cursor_addr,
  input  logic [3:0]  cursor_start,
  input  logic [3:0]  cursor_end,
  output logic [11:0] vram_addr,
  output logic        vram_rd,
  input  logic [15:0] vram_data,
  output logic [11:0] font_addr,
  output logic        load,
  output logic [7:0]  attribute_data,
  output logic [2:0]  char_msbs,
  output logic        cursor_active,
  output logic        blink_state
);

  // state | meaning
  // IDLE  | no line in progress; load and vram_rd held low
  // FETCH | stepping dot 0..8 per slot across columns 0..COLS-1
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  localparam int            FW         = $clog2(BLINK_FRAMES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    COL_LAST   = 7'(COLS - 1);

  state_t        state_q, state_d;
  logic [3:0]    dot_q, dot_d;
  logic [6:0]    col_q, col_d;
  logic [11:0]   row_base_q, row_base_d;
  logic [11:0]   vram_addr_q, vram_addr_d;
  logic          vram_rd_q, vram_rd_d;
  logic [11:0]   font_addr_q, font_addr_d;
  logic          load_q, load_d;
  logic [7:0]    attr_q, attr_d;
  logic [2:0]    msbs_q, msbs_d;
  logic          cursor_q, cursor_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;

  logic [11:0]   row_off;
  logic [11:0]   cell_addr;
  logic          cursor_phase;
  logic          cursor_hit;

`ifdef CURSOR_BLINK_EN
  localparam logic [FW-1:0] HALF_LAST = FW'(BLINK_FRAMES / 2 - 1);
  logic phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (frame_start && (frame_q == HALF_LAST || frame_q == FRAME_LAST)) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= 1'b0;
    else          phase_q <= phase_d;
  end

  assign cursor_phase = phase_q;
`else
  assign cursor_phase = 1'b1;
`endif

  assign row_off    = 12'(char_row) * 12'(COLS);
  assign cell_addr  = row_base_q + {5'b0, col_q};
  assign cursor_hit = cursor_en && (cell_addr == cursor_addr) &&
                      (cursor_start <= scanline) && (scanline <= cursor_end) &&
                      cursor_phase;

  always_comb begin
    state_d     = state_q;
    dot_d       = dot_q;
    col_d       = col_q;
    row_base_d  = row_base_q;
    vram_addr_d = vram_addr_q;
    vram_rd_d   = 1'b0;
    load_d      = 1'b0;
    font_addr_d = font_addr_q;
    attr_d      = attr_q;
    msbs_d      = msbs_q;
    cursor_d    = cursor_q;

    if (line_start) begin
      // outputs are registered, so dot 0 of column 0 is set up here
      state_d     = FETCH;
      dot_d       = 4'd0;
      col_d       = 7'd0;
      row_base_d  = start_addr + row_off;
      vram_addr_d = start_addr + row_off;
      vram_rd_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          dot_d = 4'd0;
          col_d = 7'd0;
        end
        FETCH: begin
          if (dot_q == 4'd1) begin
            // vram_data is valid during dot 1; results become visible at dot 2
            attr_d      = vram_data[15:8];
            msbs_d      = vram_data[7:5];
            font_addr_d = {vram_data[7:0], scanline};
            cursor_d    = cursor_hit;
          end
          if (dot_q == 4'd7) begin
            load_d = 1'b1;
          end
          if (dot_q == 4'd8) begin
            dot_d = 4'd0;
            if (col_q == COL_LAST) begin
              state_d = IDLE;
              col_d   = 7'd0;
            end else begin
              col_d       = col_q + 7'd1;
              vram_addr_d = cell_addr + 12'd1;
              vram_rd_d   = 1'b1;
            end
          end else begin
            dot_d = dot_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_d = frame_q;
    blink_d = blink_q;
    if (frame_start) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dot_q       <= 4'd0;
      col_q       <= 7'd0;
      row_base_q  <= 12'd0;
      vram_addr_q <= 12'd0;
      vram_rd_q   <= 1'b0;
      font_addr_q <= 12'd0;
      load_q      <= 1'b0;
      attr_q      <= 8'd0;
      msbs_q      <= 3'd0;
      cursor_q    <= 1'b0;
      frame_q     <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dot_q       <= dot_d;
      col_q       <= col_d;
      row_base_q  <= row_base_d;
      vram_addr_q <= vram_addr_d;
      vram_rd_q   <= vram_rd_d;
      font_addr_q <= font_addr_d;
      load_q      <= load_d;
      attr_q      <= attr_d;
      msbs_q      <= msbs_d;
      cursor_q    <= cursor_d;
      frame_q     <= frame_d;
      blink_q     <= blink_d;
    end
  end

  assign vram_addr      = vram_addr_q;
  assign vram_rd        = vram_rd_q;
  assign font_addr      = font_addr_q;
  assign load           = load_q;
  assign attribute_data = attr_q;
  assign char_msbs      = msbs_q;
  assign cursor_active  = cursor_q;
  assign blink_state    = blink_q;

endmodule

// File: tb/tb_char_fetch.sv
// Directed self-checking bench for char_fetch with default COLS=80, BLINK_FRAMES=16.
module tb_char_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic        frame_start = 1'b0;
  logic [4:0]  char_row = 5'd2;
  logic [3:0]  scanline = 4'd5;
  logic [11:0] start_addr = 12'h100;
  logic        cursor_en = 1'b1;
  logic [11:0] cursor_addr = 12'h1A3;
  logic [3:0]  cursor_start = 4'd13;
  logic [3:0]  cursor_end = 4'd14;
  logic [11:0] vram_addr;
  logic        vram_rd;
  logic [15:0] vram_data = 16'h1EC4;
  logic [11:0] font_addr;
  logic        load;
  logic [7:0]  attribute_data;
  logic [2:0]  char_msbs;
  logic        cursor_active;
  logic        blink_state;

  int checks = 0;
  int errors = 0;

`ifdef CURSOR_BLINK_EN
  localparam int CUR_CELL_CYCLES = 0;
  localparam logic CUR_AT_LOAD = 1'b0;
`else
  localparam int CUR_CELL_CYCLES = 9;
  localparam logic CUR_AT_LOAD = 1'b1;
`endif

  int r_loads, r_rds, r_load_err, r_rd_err, r_addr_err, r_cur;
  logic [11:0] r_font;
  logic [7:0]  r_attr;
  logic [2:0]  r_msbs;
  logic        r_cur_load3;

  char_fetch dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .frame_start(frame_start),
    .char_row(char_row), .scanline(scanline), .start_addr(start_addr),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr), .cursor_start(cursor_start),
    .cursor_end(cursor_end), .vram_addr(vram_addr), .vram_rd(vram_rd),
    .vram_data(vram_data), .font_addr(font_addr), .load(load),
    .attribute_data(attribute_data), .char_msbs(char_msbs),
    .cursor_active(cursor_active), .blink_state(blink_state)
  );

  always #5 clk = ~clk;

  `define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row base 0x100 + 2*80 = 0x1A0; expected slots are counted from the latest line_start.
  task automatic run_line(input int scan, input int abort_at);
    int base, rel;
    logic el, er;
    scanline = 4'(scan);
    r_loads = 0; r_rds = 0; r_load_err = 0; r_rd_err = 0; r_addr_err = 0; r_cur = 0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int k = 1; k <= 830; k++) begin
      base = (abort_at > 0 && k > abort_at) ? abort_at : 0;
      rel  = k - base;
      el = (rel >= 9) && ((rel - 9) % 9 == 0) && ((rel - 9) / 9 < 80);
      er = (rel >= 1) && ((rel - 1) % 9 == 0) && ((rel - 1) / 9 < 80);
      if (load) r_loads++;
      if (vram_rd) r_rds++;
      if (load !== el) r_load_err++;
      if (vram_rd !== er) r_rd_err++;
      if (er && vram_addr !== 12'(32'h1A0 + (rel - 1) / 9)) r_addr_err++;
      if (cursor_active) r_cur++;
      if (k == 3) r_font = font_addr;
      if (k == 9) begin r_attr = attribute_data; r_msbs = char_msbs; end
      if (k == 36) r_cur_load3 = cursor_active;
      line_start = (k == abort_at);
      tick();
    end
    line_start = 1'b0;
  endtask

  initial begin
    int quiet;
    logic expb;

    // reset state
    tick(); tick();
    `CHK("rst_vram_addr", vram_addr, 12'h000)
    `CHK("rst_vram_rd", vram_rd, 1'b0)
    `CHK("rst_font_addr", font_addr, 12'h000)
    `CHK("rst_load", load, 1'b0)
    `CHK("rst_attr", attribute_data, 8'h00)
    `CHK("rst_msbs", char_msbs, 3'b000)
    `CHK("rst_cursor", cursor_active, 1'b0)
    `CHK("rst_blink", blink_state, 1'b0)
    reset_n = 1'b1;
    tick();

    // full line, scanline 5: cursor row range excludes it
    run_line(5, 0);
    `CHK("lineA_loads", r_loads, 80)
    `CHK("lineA_rds", r_rds, 80)
    `CHK("lineA_load_timing", r_load_err, 0)
    `CHK("lineA_rd_timing", r_rd_err, 0)
    `CHK("lineA_vram_addr", r_addr_err, 0)
    `CHK("lineA_font_addr", r_font, 12'hC45)
    `CHK("lineA_attr", r_attr, 8'h1E)
    `CHK("lineA_msbs", r_msbs, 3'b110)
    `CHK("lineA_cursor_off", r_cur, 0)
    `CHK("idle_font_retained", font_addr, 12'hC45)

    // cursor rows 13..14 at column 3
    run_line(13, 0);
    `CHK("cur13_cycles", r_cur, CUR_CELL_CYCLES)
    `CHK("cur13_at_load3", r_cur_load3, CUR_AT_LOAD)
    run_line(14, 0);
    `CHK("cur14_cycles", r_cur, CUR_CELL_CYCLES)
    run_line(12, 0);
    `CHK("cur12_off", r_cur, 0)
    cursor_start = 4'd15;
    cursor_end   = 4'd14;
    run_line(15, 0);
    `CHK("cur_inverted15", r_cur, 0)
    run_line(14, 0);
    `CHK("cur_inverted14", r_cur, 0)

    // restart mid-line at T+100
    run_line(5, 100);
    `CHK("abort_load_timing", r_load_err, 0)
    `CHK("abort_rd_timing", r_rd_err, 0)
    `CHK("abort_vram_addr", r_addr_err, 0)
    `CHK("abort_loads", r_loads, 91)
    `CHK("abort_rds", r_rds, 92)

    // asynchronous reset at dot 5 of column 0
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset_n = 1'b0;
    #1;
    `CHK("mid_rst_vram_addr", vram_addr, 12'h000)
    `CHK("mid_rst_vram_rd", vram_rd, 1'b0)
    `CHK("mid_rst_font_addr", font_addr, 12'h000)
    `CHK("mid_rst_load", load, 1'b0)
    `CHK("mid_rst_attr", attribute_data, 8'h00)
    `CHK("mid_rst_msbs", char_msbs, 3'b000)
    `CHK("mid_rst_cursor", cursor_active, 1'b0)
    `CHK("mid_rst_blink", blink_state, 1'b0)
    tick(); tick();
    reset_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      if (load || vram_rd) quiet++;
      tick();
    end
    `CHK("post_rst_quiet", quiet, 0)
    run_line(5, 0);
    `CHK("post_rst_loads", r_loads, 80)
    `CHK("post_rst_load_timing", r_load_err, 0)

    // blink timebase; first frame_start coincides with line_start
    for (int n = 1; n <= 64; n++) begin
      frame_start = 1'b1;
      line_start  = (n == 1);
      tick();
      frame_start = 1'b0;
      line_start  = 1'b0;
      if (n == 1) begin
        `CHK("coincident_vram_rd", vram_rd, 1'b1)
        `CHK("coincident_vram_addr", vram_addr, 12'h1A0)
      end
      if (n % 16 == 0 || n % 16 == 15) begin
        expb = 1'((n / 16) % 2);
        `CHK("blink_state", blink_state, expb)
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_fetch.md
# char_fetch

Text-mode character fetch sequencer; sits directly upstream of the pixel generator. Per 9-dot character slot it reads the character/attribute word from VRAM, addresses the font ROM, and drives the generator's load strobe. It also supplies the attribute byte, character MSbs, cursor and blink signals, all timed to that strobe. Runs on the pixel clock alongside the CRTC timing logic.

## Interface
Parameters:
- COLS, 80, character columns per row (1..127)
- BLINK_FRAMES, 16, frames per blink_state half-period (even, ≥2)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  reset, asynchronous, active-low
- line_start  in  1  one-cycle pulse starting a text scanline fetch
- frame_start  in  1  one-cycle pulse per frame (blink timebase)
- char_row  in  5  character row of the current scanline
- scanline  in  4  scanline within the character cell (0..15)
- start_addr  in  12  VRAM word address of row 0, column 0
- cursor_en  in  1  cursor display enable
- cursor_addr  in  12  VRAM word address of the cursor cell
- cursor_start, cursor_end  in  4 each  first/last cursor scanline (inclusive)
- vram_addr  out  12  VRAM word address, registered
- vram_rd  out  1  VRAM read strobe
- vram_data  in  16  [7:0] character code, [15:8] attribute; valid the cycle after vram_rd
- font_addr  out  12  {char_code, scanline}, registered
- load  out  1  load strobe to pixel generator
- attribute_data  out  8  attribute of the character being loaded
- char_msbs  out  3  character code [7:5]
- cursor_active  out  1  cursor covers this cell on this scanline
- blink_state  out  1  text blink phase

## Operation
- States: IDLE, FETCH. Dot counter dot (0..8) and column counter col (0..COLS-1) are active only in FETCH.
- line_start (any state): latch row_base = start_addr + char_row*COLS (mod 4096); set col=0, dot=0; enter FETCH. A line_start during FETCH aborts the current line and restarts at column 0.
- Per slot in FETCH:
  - dot 0: vram_addr = row_base+col (mod 4096), vram_rd=1.
  - dot 1: latch vram_data into char/attr holding registers.
  - dot 2: font_addr = {char, scanline}. cursor_active is registered: cursor_en & (row_base+col == cursor_addr) & (cursor_start ≤ scanline ≤ cursor_end) [& cursor phase, see Configuration].
  - dot 8: load=1.
- attribute_data, char_msbs and cursor_active hold from their update until the next slot's update, so they are stable during load.
- After dot 8 of col=COLS-1, return to IDLE. load and vram_rd stay 0 in IDLE. font_addr and the holding registers retain their values.
- cursor_start > cursor_end: cursor never active.
- Blink: frame counter increments on frame_start and wraps at BLINK_FRAMES-1. blink_state toggles on each wrap.

## Timing
- line_start at cycle T: dot 0 of column 0 is T+1. Column k load is at T+9+9k. Column k's first pixel leaves the pixel generator at T+10+9k.
- The font ROM is synchronous (1-cycle); font_data is valid from dot 3 until the next dot 3.
- vram_rd is high for exactly one cycle per slot.
- Reset (asynchronous, any time, including mid-line): state IDLE; dot, col, frame counter and row_base cleared. All outputs 0: vram_addr, vram_rd, font_addr, load, attribute_data, char_msbs, cursor_active, blink_state. Release returns to normal operation on the next line_start.
- A frame_start coincident with line_start: both take effect in the same cycle.

## Configuration
- CURSOR_BLINK_EN defined: cursor phase toggles every BLINK_FRAMES/2 frames. cursor_active additionally requires phase=1; the phase resets to 0.
- CURSOR_BLINK_EN undefined: cursor steady; no phase term.

## Test plan
- Reset mid-FETCH at dot 5 -> all outputs 0 immediately. No load occurs until line_start after release.
- start_addr=0x100, char_row=2, COLS=80, line_start at T -> vram_addr=0x1A0 at T+1; load at T+9, T+18, …, T+720; exactly 80 loads and 80 vram_rd pulses.
- vram_data=0x1EC4, scanline=5 -> font_addr=0xC45. At that slot's load: attribute_data=0x1E, char_msbs=3'b110.
- cursor_addr=row_base+3, cursor_start=13, cursor_end=14, cursor_en=1 -> cursor_active=1 only at col 3 on scanlines 13–14. With cursor_start=15, cursor_end=14 -> never active.
- Second line_start at T+100 -> next vram_addr=row_base and next load at T+109. No stale load from the aborted slot.
- 64 frame_start pulses with BLINK_FRAMES=16 -> blink_state toggles at frames 16, 32, 48, 64. With CURSOR_BLINK_EN, the cursor phase toggles every 8 frames.
